// File: rtl/display_scan_ctrl_pkg.sv
// Shared definitions for the seven-segment scan controller: state encoding,
// blank selection code and a nibble extraction helper.
package display_scan_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHOW  = 2'd1,
        GUARD = 2'd2
    } scan_state_t;

    localparam logic [2:0] SEL_OFF  = 3'b111;
    localparam int         NIBBLE_W = 4;

    function automatic logic [NIBBLE_W-1:0] nibble_of(input logic [15:0] value,
                                                      input logic [1:0]  idx);
        logic [15:0] shifted;
        shifted = value >> {idx, 2'b00};
        return shifted[NIBBLE_W-1:0];
    endfunction

endpackage

// File: rtl/display_scan_tick.sv
// Slot prescaler: counts 0..PRESCALE_MAX-1 while enabled and pulses tick on
// the last count, wrapping to 0.
module display_scan_tick #(
    parameter int PRESCALE_MAX   = 50000,
    parameter int PRESCALE_WIDTH = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam logic [PRESCALE_WIDTH-1:0] COUNT_LAST = PRESCALE_WIDTH'(PRESCALE_MAX - 1);

    logic [PRESCALE_WIDTH-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= (count == COUNT_LAST) ? '0 : count + 1'b1;
        end
    end

    assign tick = enable && !clear && (count == COUNT_LAST);

endmodule

// File: rtl/display_scan_ctrl.sv
// Multiplexed seven-segment scan sequencer with blank guard slots and
// frame-aligned double-buffered value updates. Optional leading-zero
// blanking is enabled by defining DISPLAY_SCAN_CTRL_LEADING_ZERO_BLANK_EN.
module display_scan_ctrl
    import display_scan_ctrl_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int PRESCALE_MAX   = 50000,
    parameter int PRESCALE_WIDTH = 16,
    parameter int GUARD_CYCLES   = 4,
    parameter int GUARD_WIDTH    = 4
) (
    input  logic        DISPLAY_SCAN_CTRL_CLOCK_50,
    input  logic        DISPLAY_SCAN_CTRL_RESET_InLow,
    input  logic        DISPLAY_SCAN_CTRL_enable_In,
    input  logic        DISPLAY_SCAN_CTRL_load_In,
    input  logic [15:0] DISPLAY_SCAN_CTRL_value_InBUS,
    output logic [2:0]  DISPLAY_SCAN_CTRL_selection_OutBUS,
    output logic [3:0]  DISPLAY_SCAN_CTRL_nibble_OutBUS,
    output logic        DISPLAY_SCAN_CTRL_pending_Out,
    output logic        DISPLAY_SCAN_CTRL_frameDone_Out
);

    localparam logic [1:0]             DIGIT_LAST = 2'(NUM_DIGITS - 1);
    localparam logic [GUARD_WIDTH-1:0] GUARD_LAST =
        GUARD_WIDTH'((GUARD_CYCLES == 0) ? 0 : GUARD_CYCLES - 1);

    logic        clk;
    logic        rst_n;
    logic        scan_en;
    logic        load_pulse;
    logic [15:0] value_in;

    assign clk        = DISPLAY_SCAN_CTRL_CLOCK_50;
    assign rst_n      = DISPLAY_SCAN_CTRL_RESET_InLow;
    assign scan_en    = DISPLAY_SCAN_CTRL_enable_In;
    assign load_pulse = DISPLAY_SCAN_CTRL_load_In;
    assign value_in   = DISPLAY_SCAN_CTRL_value_InBUS;

    scan_state_t            state_q;
    logic [1:0]             digit_q;
    logic [GUARD_WIDTH-1:0] guard_cnt;
    logic [15:0]            active_q;
    logic [15:0]            shadow_q;
    logic                   pending_q;
    logic [2:0]             sel_q;
    logic [3:0]             nib_q;
    logic                   frame_done_q;

    logic        tick;
    logic [1:0]  digit_adv;
    logic [1:0]  show_digit;
    logic        adv;
    logic        boundary;
    logic [15:0] active_next;
    logic [2:0]  show_sel;
    logic [3:0]  show_nib;

    display_scan_tick #(
        .PRESCALE_MAX  (PRESCALE_MAX),
        .PRESCALE_WIDTH(PRESCALE_WIDTH)
    ) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (!(state_q == SHOW && scan_en)),
        .enable(state_q == SHOW),
        .tick  (tick)
    );

`ifdef DISPLAY_SCAN_CTRL_LEADING_ZERO_BLANK_EN
    function automatic logic lead_zero(input logic [15:0] v, input logic [1:0] d);
        logic nonzero_above;
        nonzero_above = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (i >= int'(d) && nibble_of(v, 2'(i)) != '0) nonzero_above = 1'b1;
        end
        return (d != 2'd0) && !nonzero_above;
    endfunction
`endif

    // Decide the next digit to show and the value it will be shown from; the
    // frame-boundary transfer must already be visible in digit 0's nibble.
    always_comb begin
        digit_adv = (digit_q == DIGIT_LAST) ? 2'd0 : digit_q + 2'd1;
        adv       = 1'b0;
        if (scan_en) begin
            if (state_q == SHOW && tick && GUARD_CYCLES == 0) adv = 1'b1;
            if (state_q == GUARD && guard_cnt == GUARD_LAST) adv = 1'b1;
        end
        boundary = adv && (digit_q == DIGIT_LAST);

        active_next = active_q;
        if (state_q == IDLE && load_pulse) active_next = value_in;
        else if (boundary && pending_q)    active_next = shadow_q;

        show_digit = (state_q == IDLE) ? 2'd0 : digit_adv;
        show_sel   = {1'b0, show_digit};
        show_nib   = nibble_of(active_next, show_digit);
`ifdef DISPLAY_SCAN_CTRL_LEADING_ZERO_BLANK_EN
        if (lead_zero(active_next, show_digit)) begin
            show_sel = SEL_OFF;
            show_nib = '0;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            digit_q      <= '0;
            guard_cnt    <= '0;
            active_q     <= '0;
            shadow_q     <= '0;
            pending_q    <= 1'b0;
            sel_q        <= SEL_OFF;
            nib_q        <= '0;
            frame_done_q <= 1'b0;
        end else begin
            active_q     <= active_next;
            frame_done_q <= boundary;

            // A load on the boundary clock still wins over the transfer's clear.
            if (load_pulse) begin
                if (state_q == IDLE) begin
                    pending_q <= 1'b0;
                end else begin
                    shadow_q  <= value_in;
                    pending_q <= 1'b1;
                end
            end else if (boundary) begin
                pending_q <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    digit_q   <= '0;
                    guard_cnt <= '0;
                    if (scan_en) begin
                        state_q <= SHOW;
                        sel_q   <= show_sel;
                        nib_q   <= show_nib;
                    end else begin
                        sel_q <= SEL_OFF;
                        nib_q <= '0;
                    end
                end
                SHOW: begin
                    if (!scan_en) begin
                        state_q   <= IDLE;
                        digit_q   <= '0;
                        guard_cnt <= '0;
                        sel_q     <= SEL_OFF;
                        nib_q     <= '0;
                    end else if (tick) begin
                        if (GUARD_CYCLES == 0) begin
                            digit_q <= digit_adv;
                            sel_q   <= show_sel;
                            nib_q   <= show_nib;
                        end else begin
                            state_q   <= GUARD;
                            guard_cnt <= '0;
                            sel_q     <= SEL_OFF;
                            nib_q     <= '0;
                        end
                    end
                end
                GUARD: begin
                    if (!scan_en) begin
                        state_q   <= IDLE;
                        digit_q   <= '0;
                        guard_cnt <= '0;
                        sel_q     <= SEL_OFF;
                        nib_q     <= '0;
                    end else if (guard_cnt == GUARD_LAST) begin
                        state_q   <= SHOW;
                        digit_q   <= digit_adv;
                        guard_cnt <= '0;
                        sel_q     <= show_sel;
                        nib_q     <= show_nib;
                    end else begin
                        guard_cnt <= guard_cnt + 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    sel_q   <= SEL_OFF;
                    nib_q   <= '0;
                end
            endcase
        end
    end

    assign DISPLAY_SCAN_CTRL_selection_OutBUS = sel_q;
    assign DISPLAY_SCAN_CTRL_nibble_OutBUS    = nib_q;
    assign DISPLAY_SCAN_CTRL_pending_Out      = pending_q;
    assign DISPLAY_SCAN_CTRL_frameDone_Out    = frame_done_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed scoreboard bench for display_scan_ctrl: one instance with a one-clock
// guard slot and one without, both with 4-clock display slots.
module tb_display_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable, load;
    logic [15:0] value;
    logic [2:0]  sel;
    logic [3:0]  nib;
    logic        pend, fd;

    logic        ng_enable, ng_load;
    logic [15:0] ng_value;
    logic [2:0]  ng_sel;
    logic [3:0]  ng_nib;
    logic        ng_pend, ng_fd;

    int checks   = 0;
    int failures = 0;
    bit use_ng   = 1'b0;

    typedef struct packed {
        logic [2:0] sel;
        logic [3:0] nib;
        logic       fd;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    display_scan_ctrl #(
        .NUM_DIGITS(4), .PRESCALE_MAX(4), .PRESCALE_WIDTH(16),
        .GUARD_CYCLES(1), .GUARD_WIDTH(4)
    ) dut (
        .DISPLAY_SCAN_CTRL_CLOCK_50        (clk),
        .DISPLAY_SCAN_CTRL_RESET_InLow     (rst_n),
        .DISPLAY_SCAN_CTRL_enable_In       (enable),
        .DISPLAY_SCAN_CTRL_load_In         (load),
        .DISPLAY_SCAN_CTRL_value_InBUS     (value),
        .DISPLAY_SCAN_CTRL_selection_OutBUS(sel),
        .DISPLAY_SCAN_CTRL_nibble_OutBUS   (nib),
        .DISPLAY_SCAN_CTRL_pending_Out     (pend),
        .DISPLAY_SCAN_CTRL_frameDone_Out   (fd)
    );

    display_scan_ctrl #(
        .NUM_DIGITS(4), .PRESCALE_MAX(4), .PRESCALE_WIDTH(16),
        .GUARD_CYCLES(0), .GUARD_WIDTH(4)
    ) dut_ng (
        .DISPLAY_SCAN_CTRL_CLOCK_50        (clk),
        .DISPLAY_SCAN_CTRL_RESET_InLow     (rst_n),
        .DISPLAY_SCAN_CTRL_enable_In       (ng_enable),
        .DISPLAY_SCAN_CTRL_load_In         (ng_load),
        .DISPLAY_SCAN_CTRL_value_InBUS     (ng_value),
        .DISPLAY_SCAN_CTRL_selection_OutBUS(ng_sel),
        .DISPLAY_SCAN_CTRL_nibble_OutBUS   (ng_nib),
        .DISPLAY_SCAN_CTRL_pending_Out     (ng_pend),
        .DISPLAY_SCAN_CTRL_frameDone_Out   (ng_fd)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push_slot(input logic [2:0] s, input logic [3:0] n, input logic f, input int cnt);
        exp_t e;
        for (int i = 0; i < cnt; i++) begin
            e.sel = s;
            e.nib = n;
            e.fd  = (i == 0) ? f : 1'b0;
            exp_q.push_back(e);
        end
    endtask

    // Expected frame: digit k shows nibble k of v, optionally followed by a guard slot.
    task automatic push_frame(input logic [15:0] v, input logic first_fd, input logic with_guard);
        logic [15:0] rest;
        logic [2:0]  s;
        logic [3:0]  n;
        for (int d = 0; d < 4; d++) begin
            rest = v >> (4 * d);
            n    = rest[3:0];
            s    = {1'b0, 2'(d)};
`ifdef DISPLAY_SCAN_CTRL_LEADING_ZERO_BLANK_EN
            if (d != 0 && rest == 16'h0000) begin
                s = 3'b111;
                n = 4'h0;
            end
`endif
            push_slot(s, n, (d == 0) ? first_fd : 1'b0, 4);
            if (with_guard) push_slot(3'b111, 4'h0, 1'b0, 1);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            step();
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $error("[TB] FAIL scoreboard_empty observed=0 expected=entry");
            end else begin
                e = exp_q.pop_front();
                if (use_ng) begin
                    check("ng_selection", 16'(ng_sel), 16'(e.sel));
                    check("ng_nibble", 16'(ng_nib), 16'(e.nib));
                    check("ng_frameDone", 16'(ng_fd), 16'(e.fd));
                end else begin
                    check("selection", 16'(sel), 16'(e.sel));
                    check("nibble", 16'(nib), 16'(e.nib));
                    check("frameDone", 16'(fd), 16'(e.fd));
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n = 1'b0; enable = 1'b0; load = 1'b0; value = '0;
        ng_enable = 1'b0; ng_load = 1'b0; ng_value = '0;
        repeat (2) step();
        check("reset_selection", 16'(sel), 16'h0007);
        check("reset_nibble", 16'(nib), 16'h0000);
        check("reset_pending", 16'(pend), 16'h0000);
        check("reset_frameDone", 16'(fd), 16'h0000);
        rst_n = 1'b1;

        // Load in IDLE goes straight to the active register.
        value = 16'h1234; load = 1'b1;
        step();
        load = 1'b0;
        check("idle_load_selection", 16'(sel), 16'h0007);
        check("idle_load_pending", 16'(pend), 16'h0000);

        enable = 1'b1;
        push_frame(16'h1234, 1'b0, 1'b1);
        push_frame(16'h1234, 1'b1, 1'b1);
        run(20);
        run(6);
        value = 16'hABCD; load = 1'b1;
        run(1);
        load = 1'b0;
        check("pending_after_load", 16'(pend), 16'h0001);
        run(13);
        push_frame(16'hABCD, 1'b1, 1'b1);
        run(1);
        check("pending_after_boundary", 16'(pend), 16'h0000);

        // Two loads in one frame: last wins.
        run(2);
        value = 16'h1111; load = 1'b1;
        run(1);
        value = 16'h2222;
        run(1);
        load = 1'b0;
        run(15);
        push_frame(16'h2222, 1'b1, 1'b1);
        push_frame(16'h4444, 1'b1, 1'b1);
        push_frame(16'h5555, 1'b1, 1'b1);
        run(10);
        value = 16'h4444; load = 1'b1;
        run(1);
        load = 1'b0;
        run(9);
        // Load on the boundary clock: old shadow transfers, new one pends.
        value = 16'h5555; load = 1'b1;
        run(1);
        load = 1'b0;
        check("pending_boundary_load", 16'(pend), 16'h0001);
        run(19);
        run(20);

        // Drop enable during a guard slot, then re-enable.
        push_slot(3'b000, 4'h5, 1'b1, 4);
        push_slot(3'b111, 4'h0, 1'b0, 1);
        run(5);
        enable = 1'b0;
        push_slot(3'b111, 4'h0, 1'b0, 3);
        run(3);
        enable = 1'b1;
        push_frame(16'h5555, 1'b0, 1'b1);
        run(1);
        value = 16'h0050; load = 1'b1;
        run(1);
        load = 1'b0;
        run(18);
        push_frame(16'h0050, 1'b1, 1'b1);
        run(1);
        value = 16'h0000; load = 1'b1;
        run(1);
        load = 1'b0;
        run(18);
        push_slot(3'b000, 4'h0, 1'b1, 2);
        run(2);

        // Asynchronous reset mid-slot.
        rst_n = 1'b0;
        #1;
        check("async_reset_selection", 16'(sel), 16'h0007);
        check("async_reset_frameDone", 16'(fd), 16'h0000);
        enable = 1'b0;
        step();
        rst_n = 1'b1;

        // No guard slots: digits follow each other directly.
        use_ng = 1'b1;
        ng_value = 16'h1234; ng_load = 1'b1;
        step();
        ng_load = 1'b0;
        ng_enable = 1'b1;
        push_frame(16'h1234, 1'b0, 1'b0);
        push_slot(3'b000, 4'h4, 1'b1, 1);
        run(17);
        check("ng_pending", 16'(ng_pend), 16'h0000);

        check("queue_drained", 16'(exp_q.size()), 16'h0000);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/display_scan_ctrl.md
Name: display_scan_ctrl

Overview:
- Sequencer for the 4-digit active-low anode-select decoder (3-bit selection in, 4-bit one-cold out; selection 3'b111 = all digits off).
- Time-multiplexes a 16-bit BCD/hex value onto the seven-segment display: steps the digit selection, presents the matching nibble, and inserts blank guard slots between digits to stop ghosting.
- Value updates are double-buffered and take effect only at frame boundaries, so a frame never mixes two values.

Parameters:
- NUM_DIGITS, 4, number of scanned digits (2..4); digit index runs 0..NUM_DIGITS-1.
- PRESCALE_MAX, 50000, clocks per digit display slot (at least 2).
- PRESCALE_WIDTH, 16, prescaler counter width (must hold PRESCALE_MAX-1).
- GUARD_CYCLES, 4, blank clocks between digit slots; 0 means no guard state.
- GUARD_WIDTH, 4, guard counter width.

Ports:
- DISPLAY_SCAN_CTRL_CLOCK_50  in  1  system clock
- DISPLAY_SCAN_CTRL_RESET_InLow  in  1  asynchronous active-low reset
- DISPLAY_SCAN_CTRL_enable_In  in  1  level; 1 = scan, 0 = display off
- DISPLAY_SCAN_CTRL_load_In  in  1  1-cycle pulse; capture value_InBUS
- DISPLAY_SCAN_CTRL_value_InBUS  in  16  nibble k drives digit k (bits 4k+3:4k)
- DISPLAY_SCAN_CTRL_selection_OutBUS  out  3  to the decoder selection input; 3'b111 = blank
- DISPLAY_SCAN_CTRL_nibble_OutBUS  out  4  nibble for the selected digit (to the segment decoder)
- DISPLAY_SCAN_CTRL_pending_Out  out  1  shadow value loaded, not yet active
- DISPLAY_SCAN_CTRL_frameDone_Out  out  1  1-cycle pulse at end of every frame

Behaviour:
- Reset (async, RESET_InLow=0) sets:
  - state IDLE;
  - selection=3'b111, nibble=0, frameDone=0, pending=0;
  - active and shadow registers =0;
  - prescaler, guard counter and digit index =0.
- All outputs are registered.
- States:
  - IDLE: selection 111, nibble 0, counters held at 0. If enable=1, go to SHOW with digit 0 on the next clock.
  - SHOW: selection = digit index, nibble = active[digit]. The prescaler counts 0..PRESCALE_MAX-1, so each slot lasts exactly PRESCALE_MAX clocks.
    - At count PRESCALE_MAX-1, go to GUARD, or straight to the next digit's SHOW if GUARD_CYCLES=0.
  - GUARD: selection 111, nibble 0, for exactly GUARD_CYCLES clocks. Then advance the digit index (NUM_DIGITS-1 wraps to 0) and go to SHOW.
- Frame boundary: the transition that makes digit 0 current (from GUARD or SHOW of the last digit).
  - On that same clock: frameDone=1 for one cycle.
  - If pending=1: active<=shadow and pending<=0.
- Load:
  - load=1: shadow<=value, pending<=1.
  - Load while pending: shadow is overwritten (last wins).
  - Load in IDLE: active<=value directly; pending stays 0.
  - Load coincident with a frame boundary: the transfer uses the old shadow, and the new value becomes pending.
- Enable dropped mid-scan (SHOW or GUARD): next clock goes to IDLE with selection 111; the prescaler, guard counter and digit index clear. The pending value is retained.
- Re-enable always restarts at digit 0 with a full slot.
- The digit index never exceeds NUM_DIGITS-1. Selections 3'b100..3'b110 are never driven.
- Asserting reset mid-frame forces the reset state immediately (asynchronously), without waiting for a clock edge.

Optional Feature:
- Macro: DISPLAY_SCAN_CTRL_LEADING_ZERO_BLANK_EN.
- Defined: in SHOW, a digit whose nibble and all higher-index nibbles of active are 0 drives selection 111 and nibble 0. Slot timing is unchanged. Digit 0 is never blanked, so value 0 shows a single "0".
- Undefined: every digit is always shown.

Decomposition:
- Shared package holds:
  - state encoding (IDLE=2'd0, SHOW=2'd1, GUARD=2'd2);
  - SEL_OFF=3'b111;
  - nibble width constant 4.
- One natural sub-module, display_scan_tick: prescaler with clear and enable inputs. It outputs a 1-cycle tick at count PRESCALE_MAX-1 and wraps to 0.

Test Plan (NUM_DIGITS=4, PRESCALE_MAX=4, GUARD_CYCLES=1 unless noted):
1. Reset, then load 16'h1234 in IDLE, then enable=1.
   - selection: 000 ×4, 111 ×1, 001 ×4, 111, 010 ×4, 111, 011 ×4, 111, then 000.
   - nibble: 4, 3, 2, 1 in the matching slots.
   - frameDone pulses once, on the return to 000 (every 20 clocks).
2. Load 16'hABCD while digit 1 is showing.
   - pending=1; digits 2 and 3 still show the old value.
   - At the frame boundary, pending=0 and digit 0 shows D.
3. Two loads (16'h1111 then 16'h2222) within one frame → next frame shows 2222 only. Load coincident with the boundary → that value shows one frame later.
4. Drop enable during a GUARD slot.
   - Next clock: selection=111, IDLE.
   - Re-enable: digit 0 is shown for 4 full clocks.
5. GUARD_CYCLES=0 → selection goes 000 ×4 then 001 directly, with no 111 slot. Reset asserted mid-SHOW → selection=111 immediately, without waiting for a clock edge.
6. With DISPLAY_SCAN_CTRL_LEADING_ZERO_BLANK_EN defined:
   - 16'h0050 → digits 3 and 2 are blank (111), digits 1 and 0 show 5 and 0.
   - 16'h0000 → only digit 0 is shown.
